// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// Ports:
//   Clk_Core  core clock, rising edge
//   Rst_Core  asynchronous active-high reset
//   Start     request; accepted in IDLE or DONE only
//   Op        funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   Dividend  rs1, sampled on the accept edge
//   Divisor   rs2, sampled on the accept edge
//   Busy      high in CALC and FIX
//   Done      one-cycle pulse, Result valid
//   Result    quotient or remainder, held until rewritten
//
// Build option: DIV_FASTPATH_EN sends divide-by-zero and signed overflow
// straight from accept to FIX, skipping the iterations.
//
// state | meaning
// IDLE  | waiting for a request
// CALC  | one restoring step per cycle, DWIDTH cycles
// FIX   | sign fix-up and special-case override, writes Result
// DONE  | Done asserted for one cycle; may accept the next request
module div_unit #(
    parameter int DWIDTH = 32
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core,
    input  logic              Start,
    input  logic [1:0]        Op,
    input  logic [DWIDTH-1:0] Dividend,
    input  logic [DWIDTH-1:0] Divisor,
    output logic              Busy,
    output logic              Done,
    output logic [DWIDTH-1:0] Result
);
    localparam int CW = $clog2(DWIDTH);
    localparam logic [CW-1:0]     CNT_LAST = CW'(DWIDTH - 1);
    localparam logic [DWIDTH-1:0] MIN_NEG  = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic [DWIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_next, start_state;

    logic              is_rem;
    logic              div_by_zero, overflow;
    logic              neg_quo, neg_rem;
    logic [DWIDTH-1:0] dvd_q, dvs_mag, quo, rem;
    logic [CW-1:0]     cnt;

    logic              accept;
    logic              in_signed, in_dbz, in_ovf;
    logic [DWIDTH-1:0] dvd_mag_in, dvs_mag_in;
    logic [DWIDTH:0]   rem_shift, rem_trial;
    logic [DWIDTH-1:0] quo_fixed, rem_fixed, result_fix;

    function automatic logic [DWIDTH-1:0] twos_neg(input logic [DWIDTH-1:0] x);
        return (~x) + {{(DWIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Request decode on the raw inputs, used only on the accept edge.
    always_comb begin
        accept     = Start && ((state == IDLE) || (state == DONE));
        in_signed  = ~Op[0];
        in_dbz     = (Divisor == '0);
        in_ovf     = in_signed && (Dividend == MIN_NEG) && (Divisor == ALL_ONES);
        dvd_mag_in = (in_signed && Dividend[DWIDTH-1]) ? twos_neg(Dividend) : Dividend;
        dvs_mag_in = (in_signed && Divisor[DWIDTH-1])  ? twos_neg(Divisor)  : Divisor;
`ifdef DIV_FASTPATH_EN
        start_state = (in_dbz || in_ovf) ? FIX : CALC;
`else
        start_state = CALC;
`endif
    end

    // One restoring step; the extra MSB of the trial value is the borrow.
    always_comb begin
        rem_shift = {rem, quo[DWIDTH-1]};
        rem_trial = rem_shift - {1'b0, dvs_mag};
    end

    always_comb begin
        quo_fixed = neg_quo ? twos_neg(quo) : quo;
        rem_fixed = neg_rem ? twos_neg(rem) : rem;
        if (div_by_zero)
            result_fix = is_rem ? dvd_q : ALL_ONES;
        else if (overflow)
            result_fix = is_rem ? '0 : MIN_NEG;
        else
            result_fix = is_rem ? rem_fixed : quo_fixed;
    end

    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (accept)
                    state_next = start_state;
            end
            CALC: begin
                Busy = 1'b1;
                if (cnt == CNT_LAST)
                    state_next = FIX;
            end
            FIX: begin
                Busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                Done       = 1'b1;
                state_next = accept ? start_state : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk_Core or posedge Rst_Core) begin
        if (Rst_Core) begin
            is_rem      <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            dvd_q       <= '0;
            dvs_mag     <= '0;
            quo         <= '0;
            rem         <= '0;
            cnt         <= '0;
            Result      <= '0;
        end else if (accept) begin
            is_rem      <= Op[1];
            div_by_zero <= in_dbz;
            overflow    <= in_ovf;
            neg_quo     <= in_signed && (Dividend[DWIDTH-1] ^ Divisor[DWIDTH-1]);
            neg_rem     <= in_signed && Dividend[DWIDTH-1];
            dvd_q       <= Dividend;
            dvs_mag     <= dvs_mag_in;
            quo         <= dvd_mag_in;
            rem         <= '0;
            cnt         <= '0;
        end else if (state == CALC) begin
            if (!rem_trial[DWIDTH]) begin
                rem <= rem_trial[DWIDTH-1:0];
                quo <= {quo[DWIDTH-2:0], 1'b1};
            end else begin
                rem <= rem_shift[DWIDTH-1:0];
                quo <= {quo[DWIDTH-2:0], 1'b0};
            end
            cnt <= cnt + CW'(1);
        end else if (state == FIX) begin
            Result <= result_fix;
        end
    end

endmodule
